// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - op encodings and chunk-width helper for the pipelined adder
package adder_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Returns 0 for an illegal split so the top can refuse to elaborate.
   function automatic int chunk_width(input int width, input int stages);
      if (stages < 1 || stages > width || (width % stages) != 0) begin
         return 0;
      end
      return width / stages;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational CHUNK-bit ripple of full-adder cells
module adder_slice
   import adder_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   logic carry;

   always_comb begin
      carry = cin;
      cmsb  = cin;
      sum   = '0;
      for (int i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) begin
            cmsb = carry;
         end
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined ripple-carry add/sub, one chunk per stage,
// valid chain with global stall on output backpressure
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   input  logic             op_in,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             overflow_out
);

   localparam int CHUNK = chunk_width(WIDTH, STAGES);

   if (CHUNK == 0) begin : g_bad_split
      $error("pipelined_adder: WIDTH must be a multiple of STAGES");
   end

   logic              advance;
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] carry_q;
   logic              ovf_q;
   logic [WIDTH-1:0]  a_q      [STAGES];
   logic [WIDTH-1:0]  b_q      [STAGES];
   logic [WIDTH-1:0]  sum_q    [STAGES];

   logic [WIDTH-1:0]  stage_a  [STAGES];
   logic [WIDTH-1:0]  stage_b  [STAGES];
   logic [WIDTH-1:0]  next_sum [STAGES];
   logic [STAGES-1:0] stage_cin;
   logic [STAGES-1:0] slice_cout;
   logic [WIDTH-1:0]  slice_sum;
   logic              msb_cin;

   assign advance   = ~valid_q[STAGES-1] | ready_in;
   assign ready_out = advance;

   // Stage 0 sees the live operands; later stages see the skewed copies.
   always_comb begin
      stage_a   = '{default: '0};
      stage_b   = '{default: '0};
      next_sum  = '{default: '0};
      stage_cin = '0;
      stage_a[0]   = a_in;
      stage_b[0]   = (op_in == OP_SUB) ? ~b_in : b_in;
      stage_cin[0] = (op_in == OP_SUB) ? 1'b1 : c_in;
      for (int k = 1; k < STAGES; k++) begin
         stage_a[k]   = a_q[k-1];
         stage_b[k]   = b_q[k-1];
         stage_cin[k] = carry_q[k-1];
         next_sum[k]  = sum_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         next_sum[k][k*CHUNK +: CHUNK] = slice_sum[k*CHUNK +: CHUNK];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      if (k == STAGES - 1) begin : g_last
         adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (stage_a[k][k*CHUNK +: CHUNK]),
            .b    (stage_b[k][k*CHUNK +: CHUNK]),
            .cin  (stage_cin[k]),
            .sum  (slice_sum[k*CHUNK +: CHUNK]),
            .cout (slice_cout[k]),
            .cmsb (msb_cin)
         );
      end else begin : g_mid
         logic cmsb_unused;
         adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (stage_a[k][k*CHUNK +: CHUNK]),
            .b    (stage_b[k][k*CHUNK +: CHUNK]),
            .cin  (stage_cin[k]),
            .sum  (slice_sum[k*CHUNK +: CHUNK]),
            .cout (slice_cout[k]),
            .cmsb (cmsb_unused)
         );
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_q <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else if (advance) begin
         valid_q[0] <= valid_in;
         for (int k = 1; k < STAGES; k++) begin
            valid_q[k] <= valid_q[k-1];
         end
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= stage_a[k];
            b_q[k]   <= stage_b[k];
            sum_q[k] <= next_sum[k];
         end
         carry_q <= slice_cout;
         ovf_q   <= slice_cout[STAGES-1] ^ msb_cin;
      end
   end

   assign valid_out    = valid_q[STAGES-1];
   assign sum_out      = sum_q[STAGES-1];
   assign carry_out    = carry_q[STAGES-1];
   assign overflow_out = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed and scoreboarded checks of pipelined_adder
// at STAGES = 4, 1 and 16 side by side on one shared operand bus
module tb_pipelined_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic [15:0] a, b;
   logic        c, op;
   logic [2:0]  ri, ro, vo, co, ov;
   logic [15:0] so [3];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int lat_exp [3] = '{4, 1, 16};
   logic [17:0] q0 [$];
   logic [17:0] q1 [$];
   logic [17:0] q2 [$];

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut4 (
      .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(ro[0]),
      .a_in(a), .b_in(b), .c_in(c), .op_in(op), .valid_out(vo[0]), .ready_in(ri[0]),
      .sum_out(so[0]), .carry_out(co[0]), .overflow_out(ov[0]));
   pipelined_adder #(.WIDTH(16), .STAGES(1)) u_dut1 (
      .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(ro[1]),
      .a_in(a), .b_in(b), .c_in(c), .op_in(op), .valid_out(vo[1]), .ready_in(ri[1]),
      .sum_out(so[1]), .carry_out(co[1]), .overflow_out(ov[1]));
   pipelined_adder #(.WIDTH(16), .STAGES(16)) u_dut16 (
      .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(ro[2]),
      .a_in(a), .b_in(b), .c_in(c), .op_in(op), .valid_out(vo[2]), .ready_in(ri[2]),
      .sum_out(so[2]), .carry_out(co[2]), .overflow_out(ov[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: {carry, overflow, sum} from a flat 17-bit addition.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sub);
      logic [15:0] yy;
      logic        cc;
      logic [16:0] full;
      logic        o;
      yy   = sub ? ~y : y;
      cc   = sub ? 1'b1 : ci;
      full = {1'b0, x} + {1'b0, yy} + {16'd0, cc};
      o    = (x[15] == yy[15]) && (full[15] != x[15]);
      return {full[16], o, full[15:0]};
   endfunction

   task automatic push_exp(input int d, input logic [17:0] v);
      case (d)
         0: q0.push_back(v);
         1: q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   task automatic pop_check(input int d, input string tag);
      logic [17:0] e;
      int          n;
      n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
      if (n == 0) begin
         check($sformatf("%s d%0d unexpected result", tag, d), 32'd1, 32'd0);
      end else begin
         case (d)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         check($sformatf("%s d%0d result", tag, d), {14'd0, co[d], ov[d], so[d]}, {14'd0, e});
      end
   endtask

   task automatic run_one(input string name, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic top, input logic [15:0] es,
                          input logic ec, input logic eo);
      logic [2:0] got;
      got = 3'b000;
      @(negedge clk);
      a = ta; b = tb; c = tc; op = top; valid_in = 1'b1; ri = 3'b111;
      for (int cyc = 1; cyc <= 40 && got != 3'b111; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         valid_in = 1'b0;
         for (int d = 0; d < 3; d++) begin
            if (!got[d] && vo[d]) begin
               got[d] = 1'b1;
               check($sformatf("%s d%0d latency", name, d), cyc, lat_exp[d]);
               check($sformatf("%s d%0d sum", name, d), {16'd0, so[d]}, {16'd0, es});
               check($sformatf("%s d%0d carry", name, d), {31'd0, co[d]}, {31'd0, ec});
               check($sformatf("%s d%0d ovf", name, d), {31'd0, ov[d]}, {31'd0, eo});
            end
         end
      end
      for (int d = 0; d < 3; d++) begin
         check($sformatf("%s d%0d result seen", name, d), {31'd0, got[d]}, 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] held;
      logic        was_stalled;
      logic        pending;
      logic [17:0] e;
      int          sent, recv;

      rst_n = 1'b1; valid_in = 1'b0; a = '0; b = '0; c = 1'b0; op = 1'b0; ri = 3'b111;
      #2 rst_n = 1'b0;
      #10;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset d%0d valid_out", d), {31'd0, vo[d]}, 32'd0);
         check($sformatf("reset d%0d sum_out", d), {16'd0, so[d]}, 32'd0);
         check($sformatf("reset d%0d carry/ovf", d), {30'd0, co[d], ov[d]}, 32'd0);
         check($sformatf("reset d%0d ready_out", d), {31'd0, ro[d]}, 32'd1);
      end
      @(negedge clk) rst_n = 1'b1;

      run_one("add 00ff+0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_one("add 7fff+0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_one("add ffff+0+ci", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one("add 8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_one("sub 0005-0007", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_one("sub 8000-0001", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_one("sub 0007-0005", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

      // Back-to-back stream into the 4-stage unit with a three-cycle stall.
      sent = 0; recv = 0; was_stalled = 1'b0; pending = 1'b0; held = '0;
      for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
         @(negedge clk);
         ri = {2'b11, !(cyc >= 5 && cyc <= 7)};
         #1;
         if (cyc >= 5 && cyc <= 7) begin
            check($sformatf("stall cyc%0d ready_out", cyc), {31'd0, ro[0]}, 32'd0);
            check($sformatf("stall cyc%0d valid_out", cyc), {31'd0, vo[0]}, 32'd1);
         end else begin
            check($sformatf("stream cyc%0d ready_out", cyc), {31'd0, ro[0]}, 32'd1);
         end
         if (was_stalled) begin
            check($sformatf("stall cyc%0d hold", cyc), {14'd0, co[0], ov[0], so[0]}, {14'd0, held});
         end
         was_stalled = 1'b0;
         if (vo[0]) begin
            if (ri[0]) begin
               pop_check(0, "stream");
               recv++;
            end else begin
               held = {co[0], ov[0], so[0]};
               was_stalled = 1'b1;
            end
         end
         if (sent < 8) begin
            if (!pending) begin
               a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); op = 1'($urandom);
               pending = 1'b1;
            end
            valid_in = 1'b1;
            if (ro[0]) begin
               push_exp(0, model(a, b, c, op));
               sent++;
               pending = 1'b0;
            end
         end else begin
            valid_in = 1'b0;
         end
      end
      check("stream received count", recv, 8);
      check("stream queue empty", q0.size(), 0);

      // Reset with transactions in flight: outputs drop without waiting for a clock.
      @(negedge clk);
      valid_in = 1'b0; ri = 3'b111;
      repeat (20) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 16'h1000 * 16'(i + 1); b = 16'h0101; c = 1'b0; op = 1'b0; valid_in = 1'b1;
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("async reset d%0d valid_out", d), {31'd0, vo[d]}, 32'd0);
         check($sformatf("async reset d%0d outputs", d), {14'd0, co[d], ov[d], so[d]}, 32'd0);
      end
      valid_in = 1'b0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      run_one("post-reset add", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

      // Random ADD/SUB streams with random backpressure on every build.
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            ri[d] = (cyc >= 150) ? 1'b1 : ($urandom_range(0, 3) != 0);
         end
         #1;
         for (int d = 0; d < 3; d++) begin
            if (vo[d] && ri[d]) pop_check(d, $sformatf("random cyc%0d", cyc));
         end
         if (cyc < 150) begin
            valid_in = ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); op = 1'($urandom);
         end else begin
            valid_in = 1'b0;
         end
         e = model(a, b, c, op);
         for (int d = 0; d < 3; d++) begin
            if (valid_in && ro[d]) push_exp(d, e);
         end
         if (cyc >= 150 && q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      end
      check("random d0 drained", q0.size(), 0);
      check("random d1 drained", q1.size(), 0);
      check("random d2 drained", q2.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
